// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the multi-lane D-PHY transmit sequencer.
// The state encoding is also driven out on DphyTxState.
package dphy_tx_pkg;

    typedef enum logic [2:0] {
        ST_STOP     = 3'd0,
        ST_HS_RQST  = 3'd1,
        ST_HS_PREP  = 3'd2,
        ST_HS_ZERO  = 3'd3,
        ST_HS_SYNC  = 3'd4,
        ST_HS_DATA  = 3'd5,
        ST_HS_TRAIL = 3'd6,
        ST_HS_EXIT  = 3'd7
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // LP line levels as {Dp, Dn}
    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Down-counter holds TIME-1, so clog2(max TIME) bits suffice; never go below 1 bit.
    function automatic int cnt_width(input int max_time);
        return (max_time <= 2) ? 1 : $clog2(max_time);
    endfunction

endpackage

// File: rtl/dphy_multilane_tx_seq_if.sv
// PPI-side request/data bus plus per-lane line outputs of the D-PHY TX sequencer.
interface dphy_multilane_tx_seq_if #(
    parameter int LANES = 4
);
    logic                 TxRequestHS;
    logic [LANES-1:0]     TxLaneEn;
    logic [8*LANES-1:0]   TxDataHS;
    logic                 TxReadyHS;
    logic [8*LANES-1:0]   TxByteHS;
    logic [LANES-1:0]     TxHsEn;
    logic [LANES-1:0]     TxLpDp;
    logic [LANES-1:0]     TxLpDn;
    logic                 TxClk_Enable;
    logic [2:0]           DphyTxState;
    logic                 TxStopState;

    modport master (
        output TxRequestHS, TxLaneEn, TxDataHS,
        input  TxReadyHS, TxByteHS, TxHsEn, TxLpDp, TxLpDn,
               TxClk_Enable, DphyTxState, TxStopState
    );

    modport slave (
        input  TxRequestHS, TxLaneEn, TxDataHS,
        output TxReadyHS, TxByteHS, TxHsEn, TxLpDp, TxLpDn,
               TxClk_Enable, DphyTxState, TxStopState
    );
endinterface

// File: rtl/dphy_lane_out.sv
// Per-lane output stage: registers LP levels, HS select and HS byte for the state
// being entered, so every lane output lines up with the FSM state register.
module dphy_lane_out
    import dphy_tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  tx_state_e  state,
    input  tx_state_e  nxt,
    input  logic       load,
    input  logic [7:0] data,
    output logic [7:0] hs_byte,
    output logic       hs_en,
    output logic       lp_dp,
    output logic       lp_dn
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_byte        <= '0;
            hs_en          <= 1'b0;
            {lp_dp, lp_dn} <= LP11;
        end else if (!en) begin
            hs_byte        <= '0;
            hs_en          <= 1'b0;
            {lp_dp, lp_dn} <= LP11;
        end else begin
            hs_en <= nxt inside {ST_HS_ZERO, ST_HS_SYNC, ST_HS_DATA, ST_HS_TRAIL};
            case (nxt)
                ST_HS_RQST: begin
                    {lp_dp, lp_dn} <= LP01;
                    hs_byte        <= '0;
                end
                ST_HS_PREP, ST_HS_ZERO: begin
                    {lp_dp, lp_dn} <= LP00;
                    hs_byte        <= '0;
                end
                ST_HS_SYNC: begin
                    {lp_dp, lp_dn} <= LP00;
                    hs_byte        <= SYNC_BYTE;
                end
                ST_HS_DATA: begin
                    {lp_dp, lp_dn} <= LP00;
                    if (load) hs_byte <= data;
                end
                ST_HS_TRAIL: begin
                    {lp_dp, lp_dn} <= LP00;
                    // Trail is the inverse of the last serialised bit; latch it once on entry.
                    if (state != ST_HS_TRAIL) hs_byte <= {8{~hs_byte[7]}};
                end
                default: begin
                    {lp_dp, lp_dn} <= LP11;
                    hs_byte        <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dphy_multilane_tx_seq.sv
// Multi-lane D-PHY HS transmit sequencer: one shared timing FSM walks all enabled
// lanes LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> data -> trail -> exit.
module dphy_multilane_tx_seq
    import dphy_tx_pkg::*;
#(
    parameter int LANES          = 4,
    parameter int LPX_TIME       = 2,
    parameter int HSPREPARE_TIME = 3,
    parameter int HSZERO_TIME    = 4,
    parameter int HSTRAIL_TIME   = 3,
    parameter int HSEXIT_TIME    = 5
) (
    input  logic                    TxByteClkHS,
    input  logic                    TxRst,
    dphy_multilane_tx_seq_if.slave  bus
);

    localparam int MAX_T = max_int(max_int(max_int(LPX_TIME, HSPREPARE_TIME),
                                           max_int(HSZERO_TIME, HSTRAIL_TIME)), HSEXIT_TIME);
    localparam int CNT_W = cnt_width(MAX_T);

    tx_state_e              state, nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic [LANES-1:0]       mask, mask_nxt;
    logic                   ready, clk_en, stop_st;
    logic                   accept;

    logic [LANES-1:0][7:0]  lane_byte;
    logic [LANES-1:0]       lane_hs, lane_dp, lane_dn;

    assign accept = bus.TxRequestHS & ready;

    always_comb begin
        nxt      = state;
        cnt_nxt  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        mask_nxt = mask;
        case (state)
            ST_STOP: begin
                if (bus.TxRequestHS && (|bus.TxLaneEn)) begin
                    nxt      = ST_HS_RQST;
                    cnt_nxt  = CNT_W'(LPX_TIME - 1);
                    mask_nxt = bus.TxLaneEn;
                end
            end
            ST_HS_RQST: if (cnt == '0) begin
                nxt     = ST_HS_PREP;
                cnt_nxt = CNT_W'(HSPREPARE_TIME - 1);
            end
            ST_HS_PREP: if (cnt == '0) begin
                nxt     = ST_HS_ZERO;
                cnt_nxt = CNT_W'(HSZERO_TIME - 1);
            end
            ST_HS_ZERO: if (cnt == '0) begin
                nxt     = ST_HS_SYNC;
                cnt_nxt = '0;
            end
            ST_HS_SYNC, ST_HS_DATA: begin
                if (bus.TxRequestHS) begin
                    nxt = ST_HS_DATA;
                end else begin
                    nxt     = ST_HS_TRAIL;
                    cnt_nxt = CNT_W'(HSTRAIL_TIME - 1);
                end
            end
            ST_HS_TRAIL: if (cnt == '0) begin
                nxt     = ST_HS_EXIT;
                cnt_nxt = CNT_W'(HSEXIT_TIME - 1);
            end
            ST_HS_EXIT: if (cnt == '0) begin
                nxt      = ST_STOP;
                mask_nxt = '0;
            end
            default: begin
                nxt      = ST_STOP;
                cnt_nxt  = '0;
                mask_nxt = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with DphyTxState.
    always_ff @(posedge TxByteClkHS or negedge TxRst) begin
        if (!TxRst) begin
            state   <= ST_STOP;
            cnt     <= '0;
            mask    <= '0;
            ready   <= 1'b0;
            clk_en  <= 1'b0;
            stop_st <= 1'b1;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            mask    <= mask_nxt;
            ready   <= (nxt == ST_HS_SYNC) || (nxt == ST_HS_DATA);
            clk_en  <= (nxt != ST_STOP) && (nxt != ST_HS_EXIT);
            stop_st <= (nxt == ST_STOP);
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dphy_lane_out u_lane (
            .clk     (TxByteClkHS),
            .rst_n   (TxRst),
            .en      (mask_nxt[i]),
            .state   (state),
            .nxt     (nxt),
            .load    (accept),
            .data    (bus.TxDataHS[8*i +: 8]),
            .hs_byte (lane_byte[i]),
            .hs_en   (lane_hs[i]),
            .lp_dp   (lane_dp[i]),
            .lp_dn   (lane_dn[i])
        );
    end

    assign bus.TxByteHS     = lane_byte;
    assign bus.TxHsEn       = lane_hs;
    assign bus.TxLpDp       = lane_dp;
    assign bus.TxLpDn       = lane_dn;
    assign bus.TxReadyHS    = ready;
    assign bus.TxClk_Enable = clk_en;
    assign bus.TxStopState  = stop_st;
    assign bus.DphyTxState  = state;

endmodule

// File: tb/tb_dphy_multilane_tx_seq.sv
// Directed bench for the 2-lane D-PHY TX sequencer with default timing.
// "Cycle n" is the value observed just after the n-th edge counted from the request edge.
module tb_dphy_multilane_tx_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    dphy_multilane_tx_seq_if #(.LANES(2)) bus ();

    dphy_multilane_tx_seq #(.LANES(2)) u_dut (
        .TxByteClkHS (clk),
        .TxRst       (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [27:0] observed();
        return {bus.DphyTxState, bus.TxReadyHS, bus.TxClk_Enable, bus.TxStopState,
                bus.TxHsEn, bus.TxLpDp, bus.TxLpDn, bus.TxByteHS};
    endfunction

    // Expected state for cycle n of a burst carrying nw data words.
    function automatic logic [2:0] exp_st(input int n, input int nw);
        if (n < 1)        return 3'd0;
        if (n <= 2)       return 3'd1;
        if (n <= 5)       return 3'd2;
        if (n <= 9)       return 3'd3;
        if (n == 10)      return 3'd4;
        if (n <= 10 + nw) return 3'd5;
        if (n <= 13 + nw) return 3'd6;
        if (n <= 18 + nw) return 3'd7;
        return 3'd0;
    endfunction

    // d is the DATA word or the TRAIL bytes for the cycle; m is the lane mask.
    function automatic logic [27:0] exp_out(input logic [2:0] st, input logic [15:0] d,
                                            input logic [1:0] m);
        logic [15:0] b;
        logic [1:0]  hs, dp, dn;
        b  = (st == 3'd4) ? 16'hB8B8 : ((st == 3'd5 || st == 3'd6) ? d : 16'h0000);
        hs = (st >= 3'd3 && st <= 3'd6) ? 2'b11 : 2'b00;
        dp = (st == 3'd0 || st == 3'd7) ? 2'b11 : 2'b00;
        dn = (st == 3'd0 || st == 3'd1 || st == 3'd7) ? 2'b11 : 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (!m[i]) begin
                b[8*i +: 8] = 8'h00;
                hs[i] = 1'b0;
                dp[i] = 1'b1;
                dn[i] = 1'b1;
            end
        end
        return {st, (st == 3'd4 || st == 3'd5), (st >= 3'd1 && st <= 3'd6), (st == 3'd0),
                hs, dp, dn, b};
    endfunction

    localparam logic [27:0] RST_V = {3'd0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11, 2'b11, 16'h0000};

    task automatic test_reset();
        bus.TxRequestHS = 1'b0;
        bus.TxLaneEn    = 2'b00;
        bus.TxDataHS    = 16'h0000;
        #12;
        checks++;
        if (observed() !== RST_V) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", observed(), RST_V);
        end
        #5 rst_n = 1'b1;
        step();
    endtask

    task automatic test_full_burst(input logic [1:0] m, input string name);
        logic [15:0] words [3];
        logic [15:0] d;
        logic [27:0] e;
        words = '{16'h11AA, 16'h2233, 16'h8055};
        bus.TxLaneEn = m;
        for (int n = 1; n <= 22; n++) begin
            bus.TxRequestHS = (n <= 13);
            bus.TxDataHS    = (n >= 11 && n <= 13) ? words[n-11] : 16'h0000;
            step();
            d = (n >= 11 && n <= 13) ? words[n-11] : 16'h00FF;
            e = exp_out(exp_st(n, 3), d, m);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL %s cyc %0d: got %h expected %h", name, n, observed(), e);
            end
        end
    endtask

    task automatic test_pulse();
        logic [27:0] e;
        bus.TxLaneEn = 2'b11;
        for (int n = 1; n <= 19; n++) begin
            bus.TxRequestHS = (n == 1);
            bus.TxDataHS    = 16'hFFFF;
            step();
            e = exp_out(exp_st(n, 0), 16'h0000, 2'b11);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL pulse cyc %0d: got %h expected %h", n, observed(), e);
            end
        end
    endtask

    task automatic test_zero_mask();
        bus.TxLaneEn    = 2'b00;
        bus.TxRequestHS = 1'b1;
        bus.TxDataHS    = 16'h5A5A;
        for (int n = 1; n <= 5; n++) begin
            step();
            checks++;
            if (observed() !== RST_V) begin
                errors++;
                $display("FAIL zero_mask cyc %0d: got %h expected %h", n, observed(), RST_V);
            end
        end
        bus.TxRequestHS = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [15:0] d;
        logic [27:0] e;
        bit          done;
        words = '{16'h0102, 16'hF0F0, 16'h7F80};
        bus.TxLaneEn = 2'b11;
        for (int n = 1; n <= 23; n++) begin
            // Request re-raised during TRAIL and held through EXIT/STOP
            bus.TxRequestHS = (n <= 13) || (n >= 15);
            bus.TxDataHS    = (n >= 11 && n <= 13) ? words[n-11] : 16'h0000;
            step();
            d = (n >= 11 && n <= 13) ? words[n-11] : 16'hFF00;
            e = (n == 23) ? exp_out(3'd1, 16'h0000, 2'b11) : exp_out(exp_st(n, 3), d, 2'b11);
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", n, observed(), e);
            end
        end
        bus.TxRequestHS = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step();
            if (bus.TxStopState === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done || observed() !== RST_V) begin
            errors++;
            $display("FAIL back_to_back_drain: got %h expected %h", observed(), RST_V);
        end
    endtask

    task automatic test_reset_mid_burst();
        bus.TxLaneEn = 2'b11;
        for (int n = 1; n <= 12; n++) begin
            bus.TxRequestHS = 1'b1;
            bus.TxDataHS    = 16'hC3C3;
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== RST_V) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", observed(), RST_V);
        end
        bus.TxRequestHS = 1'b0;
        #1 rst_n = 1'b1;
        step();
        checks++;
        if (observed() !== RST_V) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", observed(), RST_V);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst(2'b11, "full_burst");
        test_full_burst(2'b01, "mask01");
        test_pulse();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dphy_multilane_tx_seq.md
# dphy_multilane_tx_seq

Parametrised multi-lane D-PHY transmit sequencer running entirely in the HS byte-clock domain. On a PPI-style HS request it walks every enabled data lane through LP-11 → LP-01 → LP-00 → HS-zero → sync → data → trail → exit → LP-11. Per lane it presents LP line levels, an HS-enable select and a parallel HS byte to the downstream per-lane serialiser/driver. It generalises the single-lane LP/HS driver with:
- a lane count and lane-enable mask;
- fully parameterised timing;
- in-block sync-byte and trail generation.

## Interface
Parameters:
- LANES, 4: data lanes, 1..4.
- LPX_TIME, 2: TLPX in byte-clock cycles (≥1).
- HSPREPARE_TIME, 3: THS-PREPARE cycles (≥1).
- HSZERO_TIME, 4: THS-ZERO cycles (≥1).
- HSTRAIL_TIME, 3: THS-TRAIL cycles (≥1).
- HSEXIT_TIME, 5: THS-EXIT cycles (≥1).

Ports (one clock; reset is asynchronous and active-low):
- TxByteClkHS  in  1  byte clock; all state changes on its rising edge.
- TxRst  in  1  asynchronous, active-low reset.
- TxRequestHS  in  1  HS burst request / data-valid.
- TxLaneEn  in  LANES  lane-enable mask, sampled at burst start.
- TxDataHS  in  8*LANES  lane i byte = bits [8i+7:8i].
- TxReadyHS  out  1  byte on TxDataHS accepted at an edge where TxRequestHS & TxReadyHS.
- TxByteHS  out  8*LANES  per-lane HS byte to serialiser.
- TxHsEn  out  LANES  per-lane HS/LP mux select (1 = HS).
- TxLpDp, TxLpDn  out  LANES each  per-lane LP line levels.
- TxClk_Enable  out  1  clock-lane HS request.
- DphyTxState  out  3  current FSM state.
- TxStopState  out  1  high in STOP.

## Operation
- FSM encoding: STOP=0, HS_RQST=1, HS_PREP=2, HS_ZERO=3, HS_SYNC=4, HS_DATA=5, HS_TRAIL=6, HS_EXIT=7.
- Timed states (RQST, PREP, ZERO, TRAIL, EXIT):
  - A shared down-counter loads TIME-1 on entry.
  - The FSM advances when the counter reaches 0, so each timed state lasts exactly TIME cycles.
- STOP → HS_RQST when TxRequestHS=1 and TxLaneEn≠0.
  - TxLaneEn is registered into a lane mask on this edge and held until STOP.
  - A request with an all-zero mask is ignored.
- HS_SYNC lasts 1 cycle; then goes to HS_DATA if TxRequestHS=1, else HS_TRAIL.
- HS_DATA:
  - Each edge with TxRequestHS=1 loads TxDataHS into the lane byte registers and stays in HS_DATA.
  - TxRequestHS=0 → HS_TRAIL.
  - No idle gaps are supported; the request must stay high while data flows.
- TxRequestHS dropping during RQST/PREP/ZERO is ignored: the burst completes through SYNC, then trails (minimum burst = sync only).
- TxRequestHS during TRAIL/EXIT is ignored; it is re-evaluated in STOP.
- Per enabled lane, all outputs are registered and reflect the current state:
  - STOP/EXIT: Dp/Dn=1/1, HsEn=0, byte 0x00.
  - RQST: Dp/Dn=0/1.
  - PREP: Dp/Dn=0/0.
  - ZERO: HsEn=1, byte 0x00.
  - SYNC: HsEn=1, byte 0xB8.
  - DATA: HsEn=1, accepted byte.
  - TRAIL: HsEn=1, byte = {8{~b7}}, where b7 is bit 7 (last serialised bit, LSB-first) of the byte output in the final DATA/SYNC cycle.
- Disabled lanes hold LP-11, HsEn=0, byte 0x00 throughout.
- TxClk_Enable is high in RQST..TRAIL and low in EXIT/STOP.
- TxReadyHS is high exactly in HS_SYNC and HS_DATA.

## Timing
- Reset values: state STOP, TxLpDp=TxLpDn=all ones, TxHsEn=0, TxByteHS=0, TxReadyHS=0, TxClk_Enable=0, TxStopState=1, lane mask 0, counter 0.
- Reset mid-burst forces these values immediately (asynchronous).
- Request sampled at edge k gives:
  - RQST from cycle k+1.
  - SYNC at cycle k+1+LPX+PREP+ZERO.
  - First data byte on TxByteHS one cycle after SYNC.
- Accept-to-output latency: 1 cycle.
- Trail start: the cycle after the DATA cycle in which TxRequestHS=0 is sampled.
- Return to STOP: after TRAIL+EXIT cycles.

## Structure
- Shared package dphy_tx_pkg holds:
  - the state enum/encodings;
  - the SYNC_BYTE = 8'hB8 constant;
  - LP level constants LP11/LP01/LP00.
- Counter width is a localparam: clog2 of the maximum timing parameter.
- One natural sub-module, dphy_lane_out, generated LANES times:
  - byte register;
  - mask gating;
  - trail computation;
  - LP/HsEn decode.

## Test plan
All scenarios use LANES=2 and default timing; "cycle n" = n edges after the request is sampled.
- Reset: TxRst low mid-DATA → all outputs return to reset values immediately, state 0, no glitch on release.
- Full burst, mask 2'b11, words 0x11AA, 0x2233, 0x8055, then request low:
  - RQST cycles 1–2, PREP 3–5, ZERO 6–9.
  - SYNC 0xB8/0xB8 and TxReadyHS=1 at cycle 10.
  - Data at cycles 11–13.
  - TRAIL cycles 14–16: lane0 0xFF, lane1 0x00.
  - EXIT 17–21, STOP 22.
- Mask 2'b01: lane1 stays LP-11, HsEn=0, byte 0 for the whole burst; lane0 behaves as above.
- Request pulsed one cycle: full sequence to SYNC, TxReadyHS high only at cycle 10, TRAIL bytes 0x00 at cycles 11–13.
- Request with TxLaneEn=0: state stays STOP, outputs unchanged.
- Request held high through EXIT: a new burst starts only after the STOP cycle (RQST at cycle 23 of the prior burst).
